q_8_34b_datapath: RTL and testbench
===================================

Name: q_8_34b_datapath

Overview:
- Datapath partner of the q_8_34b controller. Decodes and executes the controller's commands: load_regs, incr_r2 and shift.
- Returns the status signals zero and E to the controller, which together implement a ones-counter on a W-bit operand.
- Captures the final count when the controller returns to ready, and flags illegal command combinations.
- Sits between the operand source and the controller. Instantiated alongside q_8_34b in the top-level counter.

Parameters:
- W, 8, operand width in bits (R1 width); legal range 2..32.
- CW, $clog2(W+1), width of count register R2 and of count_out; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst_b  input  1  asynchronous active-low reset.
- data_in  input  W  operand, sampled on load_regs.
- load_regs  input  1  controller command: R1<=data_in, R2<=all-ones, E<=0.
- incr_r2  input  1  controller command: R2<=R2+1.
- shift  input  1  controller command: R1<=R1<<1, E<=R1[W-1].
- rdy  input  1  controller ready (idle) indication.
- zero  output  1  status: R1 == 0 (combinational from R1).
- E  output  1  status: last bit shifted out of R1 (registered).
- count_out  output  CW  captured ones count.
- count_valid  output  1  count_out holds the result of the last completed operation.
- cmd_err  output  1  sticky illegal-command flag.

Behaviour:
- Reset (rst_b low, asynchronous) values:
  - R1=0, R2=0, E=0.
  - count_out=0, count_valid=0, cmd_err=0.
  - Internal rdy_q=1, so no spurious capture on reset release.
  - Reset mid-operation aborts everything; zero reads 1 after reset.
- Registers update on the rising clk edge only; commands are sampled that cycle.
- load_regs:
  - R1<=data_in; R2<=all-ones (CW bits), so the first incr yields 0; E<=0; count_valid<=0.
  - Takes priority over incr_r2/shift in the same cycle.
  - If load_regs is high together with incr_r2 or shift: load executes, the others are ignored, cmd_err<=1.
- incr_r2 without load: R2<=R2+1, modulo 2^CW (wraps silently; cannot occur under correct control).
- shift without load: R1<={R1[W-2:0],1'b0}; E<=R1[W-1].
- incr_r2 and shift together without load: both execute (independent registers); not an error.
- No command asserted: R1, R2 and E hold.
- zero:
  - Combinational (R1=={W{1'b0}}).
  - Valid in the same cycle the controller samples it in S_1, i.e. it reflects R1 after all prior shifts.
- E is registered and valid from the cycle after shift, which matches the controller's S_3 sampling.
- Result capture:
  - rdy_q<=rdy each cycle.
  - When rdy=1 and rdy_q=0 (controller just re-entered idle): count_out<=R2, count_valid<=1.
  - R2 is stable at that point because the controller's last incr_r2 was issued in S_1 before idle.
  - count_out holds until the next capture or reset.
  - count_valid clears on load_regs.
- cmd_err: set only by load_regs+incr_r2 or load_regs+shift; cleared only by reset.
- Latency: result = (#ones+1) S_1 visits plus two cycles (S_2, S_3) per shift, plus a one-cycle capture delay after rdy rises.

Test Plan (W=8, datapath paired with q_8_34b controller):
- data_in=0x00, start pulse -> zero=1 in first S_1 cycle; count_out=0, count_valid=1 one cycle after rdy rises; cmd_err=0.
- data_in=0xA5 -> E sequence after shifts 1,0,1,0,0,1,0,1 until R1==0; count_out=4, count_valid=1.
- data_in=0xFF -> count_out=8; data_in=0x80 -> count_out=1 after exactly one shift.
- Back-to-back: 0xFF then 0x01 -> count_valid drops on second load_regs; count_out=8 remains until recapture, then becomes 1.
- Datapath standalone, load_regs=1 with shift=1, data_in=0x3C -> R1=0x3C, E=0, cmd_err=1 sticky; incr_r2+shift together -> both execute, cmd_err unchanged.
- Assert rst_b low mid-count (after loading 0xFF, during S_2) -> all outputs at reset values immediately; zero=1; no count_valid pulse on release.

Source files
------------

// File: rtl/q_8_34b_datapath.sv
// q_8_34b_datapath
// Datapath partner of the q_8_34b ones-counter controller. It holds the
// operand shift register R1, the count register R2 and the shifted-out bit E.
// It returns the status signals zero and E to the controller, captures the
// final count when the controller goes back to idle, and records illegal
// command combinations in a sticky flag.
module q_8_34b_datapath #(
  parameter  int W  = 8,
  localparam int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic [W-1:0]  data_in,
  input  logic          load_regs,
  input  logic          incr_r2,
  input  logic          shift,
  input  logic          rdy,
  output logic          zero,
  output logic          E,
  output logic [CW-1:0] count_out,
  output logic          count_valid,
  output logic          cmd_err
);

  // Decoded command for the current cycle. load_regs wins over the other two
  // commands; incr_r2 and shift touch different registers, so they may run
  // together.
  typedef struct packed {
    logic do_load;
    logic do_incr;
    logic do_shift;
    logic illegal;
  } cmd_t;

  // Architectural registers.
  logic [W-1:0]  r_r1;
  logic [CW-1:0] r_r2;
  logic          r_e;

  // Result capture and error tracking.
  logic          r_rdy_q;
  logic [CW-1:0] r_count_out;
  logic          r_count_valid;
  logic          r_cmd_err;

  // Combinational helpers.
  cmd_t          w_cmd;
  logic          w_capture;
  logic [W-1:0]  w_r1_shifted;
  logic [CW-1:0] w_r2_incr;

  // Decode the controller's command lines into what actually executes.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch can be inferred.
    w_cmd          = '0;
    w_cmd.do_load  = load_regs;
    w_cmd.do_incr  = incr_r2 & ~load_regs;
    w_cmd.do_shift = shift & ~load_regs;
    w_cmd.illegal  = load_regs & (incr_r2 | shift);
  end

  // Next-value arithmetic for R1 and R2 kept apart from the register process.
  always_comb begin
    w_r1_shifted = {r_r1[W-2:0], 1'b0};
    // R2 wraps modulo 2^CW; under correct control it never reaches the wrap.
    w_r2_incr    = r_r2 + CW'(1);
    // The controller has just re-entered idle: R2 holds the finished count.
    w_capture    = rdy & ~r_rdy_q;
  end

  // R1: operand shift register, loaded from data_in and shifted left.
  always_ff @(posedge clk or negedge rst_b) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, whatever the block order.
    if (!rst_b) begin
      r_r1 <= '0;
    end else if (w_cmd.do_load) begin
      r_r1 <= data_in;
    end else if (w_cmd.do_shift) begin
      r_r1 <= w_r1_shifted;
    end
  end

  // R2: ones count, preset to all-ones on load so the first increment gives 0.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_r2 <= '0;
    end else if (w_cmd.do_load) begin
      r_r2 <= '1;
    end else if (w_cmd.do_incr) begin
      r_r2 <= w_r2_incr;
    end
  end

  // E: the bit most recently shifted out of R1, cleared on load.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_e <= 1'b0;
    end else if (w_cmd.do_load) begin
      r_e <= 1'b0;
    end else if (w_cmd.do_shift) begin
      r_e <= r_r1[W-1];
    end
  end

  // Delayed copy of rdy for edge detection. It resets to 1 so that releasing
  // reset with the controller idle does not look like a return to idle.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_rdy_q <= 1'b1;
    end else begin
      r_rdy_q <= rdy;
    end
  end

  // Result register: sampled from R2 on the rising edge of rdy.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_count_out <= '0;
    end else if (w_capture) begin
      r_count_out <= r_r2;
    end
  end

  // Result-valid flag: a new load invalidates the held result. If a load and
  // a capture coincide, the load wins, because the operation it starts makes
  // the captured value stale.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_count_valid <= 1'b0;
    end else if (w_cmd.do_load) begin
      r_count_valid <= 1'b0;
    end else if (w_capture) begin
      r_count_valid <= 1'b1;
    end
  end

  // Sticky illegal-command flag; only reset clears it.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_cmd_err <= 1'b0;
    end else if (w_cmd.illegal) begin
      r_cmd_err <= 1'b1;
    end
  end

  // zero is combinational so the controller sees it in the same S_1 cycle.
  assign zero        = (r_r1 == '0);
  assign E           = r_e;
  assign count_out   = r_count_out;
  assign count_valid = r_count_valid;
  assign cmd_err     = r_cmd_err;

endmodule

// File: tb/tb_q_8_34b_datapath.sv
// tb_q_8_34b_datapath
// Drives the datapath the way the q_8_34b controller would (idle, S_1, S_2,
// S_3), and also applies raw random command mixes. Expected values come from
// popcounts and from a small behavioural model of the registers.
module tb_q_8_34b_datapath;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_b;
  logic [W-1:0]  data_in;
  logic          load_regs;
  logic          incr_r2;
  logic          shift;
  logic          rdy;
  logic          zero;
  logic          E;
  logic [CW-1:0] count_out;
  logic          count_valid;
  logic          cmd_err;

  int total = 0;
  int bad   = 0;

  // Expected values of the result/error outputs, carried between tests.
  logic [CW-1:0] m_count_out   = '0;
  logic          m_count_valid = 1'b0;
  logic          m_cmd_err     = 1'b0;

  q_8_34b_datapath #(.W(W)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .data_in     (data_in),
    .load_regs   (load_regs),
    .incr_r2     (incr_r2),
    .shift       (shift),
    .rdy         (rdy),
    .zero        (zero),
    .E           (E),
    .count_out   (count_out),
    .count_valid (count_valid),
    .cmd_err     (cmd_err)
  );

  always #5 clk = ~clk;

  // Acts as the controller for one complete count of operand d. All decisions
  // come from a bench-side copy of the operand; the DUT status is only checked.
  task automatic run_op(input logic [W-1:0] d, input string tag,
                        output int n_shifts, output logic [W-1:0] e_seq);
    logic [W-1:0]  m_r1;
    logic [CW-1:0] exp_cnt;
    logic          exp_e;
    m_r1     = d;
    exp_cnt  = CW'($countones(d));
    n_shifts = 0;
    e_seq    = '0;
    // idle: start accepted, load issued
    @(negedge clk);
    data_in = d; load_regs = 1'b1; rdy = 1'b1;
    @(negedge clk);
    load_regs = 1'b0; rdy = 1'b0;
    total++;
    if (count_valid !== 1'b0) begin
      bad++; $display("FAIL %s valid_cleared_on_load: got %0b want 0", tag, count_valid);
    end
    total++;
    if (count_out !== m_count_out) begin
      bad++; $display("FAIL %s count_out_held: got %0d want %0d", tag, count_out, m_count_out);
    end
    for (int guard = 0; guard < 4 * W + 4; guard++) begin
      // S_1: check zero, issue incr_r2
      total++;
      if (zero !== (m_r1 == '0)) begin
        bad++; $display("FAIL %s zero_in_s1: got %0b want %0b", tag, zero, (m_r1 == '0));
      end
      incr_r2 = 1'b1;
      @(negedge clk);
      incr_r2 = 1'b0;
      if (m_r1 == '0) break;
      // S_2 / S_3 until a one is shifted out
      do begin
        shift = 1'b1;
        exp_e = m_r1[W-1];
        m_r1  = m_r1 << 1;
        n_shifts++;
        e_seq = {e_seq[W-2:0], exp_e};
        @(negedge clk);
        shift = 1'b0;
        total++;
        if (E !== exp_e) begin
          bad++; $display("FAIL %s e_after_shift%0d: got %0b want %0b", tag, n_shifts, E, exp_e);
        end
        @(negedge clk);
      end while (!exp_e);
    end
    // back in idle: rdy rises, capture happens on the next edge
    rdy = 1'b1;
    total++;
    if (count_valid !== 1'b0) begin
      bad++; $display("FAIL %s valid_before_capture: got %0b want 0", tag, count_valid);
    end
    @(negedge clk);
    m_count_out   = exp_cnt;
    m_count_valid = 1'b1;
    total++;
    if (count_out !== exp_cnt) begin
      bad++; $display("FAIL %s count_out: got %0d want %0d", tag, count_out, exp_cnt);
    end
    total++;
    if (count_valid !== 1'b1) begin
      bad++; $display("FAIL %s count_valid: got %0b want 1", tag, count_valid);
    end
    total++;
    if (cmd_err !== m_cmd_err) begin
      bad++; $display("FAIL %s cmd_err: got %0b want %0b", tag, cmd_err, m_cmd_err);
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b0; data_in = '0; load_regs = 1'b0; incr_r2 = 1'b0; shift = 1'b0; rdy = 1'b1;
    #12;
    total++;
    if ({zero, E, count_out, count_valid, cmd_err} !== {1'b1, 1'b0, {CW{1'b0}}, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset_values: got z=%0b e=%0b c=%0d v=%0b err=%0b want z=1 e=0 c=0 v=0 err=0",
                      zero, E, count_out, count_valid, cmd_err);
    end
    @(negedge clk);
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (count_valid !== 1'b0) begin
      bad++; $display("FAIL reset_release_no_capture: got %0b want 0", count_valid);
    end
  endtask

  task automatic test_zero_operand();
    int n; logic [W-1:0] s;
    run_op(8'h00, "op00", n, s);
    total++;
    if (n !== 0) begin
      bad++; $display("FAIL op00_shifts: got %0d want 0", n);
    end
  endtask

  task automatic test_a5();
    int n; logic [W-1:0] s;
    run_op(8'hA5, "opA5", n, s);
    total++;
    if (n !== 8 || s !== 8'b1010_0101) begin
      bad++; $display("FAIL opA5_e_sequence: got n=%0d seq=%b want n=8 seq=10100101", n, s);
    end
  endtask

  task automatic test_boundaries();
    int n; logic [W-1:0] s;
    run_op(8'hFF, "opFF", n, s);
    run_op(8'h80, "op80", n, s);
    total++;
    if (n !== 1) begin
      bad++; $display("FAIL op80_shifts: got %0d want 1", n);
    end
  endtask

  task automatic test_back_to_back();
    int n; logic [W-1:0] s;
    run_op(8'hFF, "b2b_first", n, s);
    run_op(8'h01, "b2b_second", n, s);
  endtask

  task automatic test_random_ops();
    int n; logic [W-1:0] s;
    for (int i = 0; i < 6; i++) begin
      run_op(W'($urandom), $sformatf("rnd_op%0d", i), n, s);
    end
  endtask

  // Load with shift at the same time, then incr+shift together, then plain
  // shifts; R1 contents are observed through E and zero, R2 through a capture.
  task automatic test_cmd_err();
    logic [W-1:0] m_r1;
    logic         exp_e;
    @(negedge clk);
    data_in = 8'h3C; load_regs = 1'b1; shift = 1'b1; rdy = 1'b1;
    @(negedge clk);
    load_regs = 1'b0; shift = 1'b0; rdy = 1'b0;
    m_r1 = 8'h3C; m_cmd_err = 1'b1; m_count_valid = 1'b0;
    total++;
    if ({zero, E, cmd_err, count_valid} !== 4'b0010) begin
      bad++; $display("FAIL load_shift_err: got z=%0b e=%0b err=%0b v=%0b want z=0 e=0 err=1 v=0",
                      zero, E, cmd_err, count_valid);
    end
    for (int i = 0; i < 6; i++) begin
      incr_r2 = (i == 0); shift = 1'b1;
      exp_e = m_r1[W-1]; m_r1 = m_r1 << 1;
      @(negedge clk);
      incr_r2 = 1'b0; shift = 1'b0;
      total++;
      if (E !== exp_e || zero !== (m_r1 == '0) || cmd_err !== 1'b1) begin
        bad++; $display("FAIL cmd_shift%0d: got e=%0b z=%0b err=%0b want e=%0b z=%0b err=1",
                        i, E, zero, cmd_err, exp_e, (m_r1 == '0));
      end
    end
    rdy = 1'b1;
    @(negedge clk);
    m_count_out = '0; m_count_valid = 1'b1;
    total++;
    if (count_out !== '0 || count_valid !== 1'b1) begin
      bad++; $display("FAIL cmd_incr_capture: got c=%0d v=%0b want c=0 v=1", count_out, count_valid);
    end
  endtask

  // Random raw command mixes, including illegal ones, against a register model.
  task automatic test_random_cmds();
    logic [W-1:0]  m_r1;
    logic [CW-1:0] m_r2;
    logic          m_e, m_rdy_q;
    logic          ld, inc, sh, r;
    logic [W-1:0]  d;
    m_r1 = '0; m_r2 = '0; m_e = 1'b0; m_rdy_q = rdy;
    for (int i = 0; i <= 300; i++) begin
      ld  = (i == 0) || ($urandom_range(7) == 0);
      inc = $urandom_range(1) == 1;
      sh  = $urandom_range(1) == 1;
      r   = $urandom_range(2) == 0;
      d   = W'($urandom);
      if (i == 300) begin ld = 1'b0; inc = 1'b0; sh = 1'b0; r = 1'b1; end
      data_in = d; load_regs = ld; incr_r2 = inc; shift = sh; rdy = r;
      if (r && !m_rdy_q) begin m_count_out = m_r2; m_count_valid = 1'b1; end
      if (ld) begin
        if (inc || sh) m_cmd_err = 1'b1;
        m_r1 = d; m_r2 = '1; m_e = 1'b0; m_count_valid = 1'b0;
      end else begin
        if (inc) m_r2 = m_r2 + 1'b1;
        if (sh) begin m_e = m_r1[W-1]; m_r1 = m_r1 << 1; end
      end
      m_rdy_q = r;
      @(negedge clk);
      total++;
      if ({zero, E, count_out, count_valid, cmd_err} !==
          {(m_r1 == '0), m_e, m_count_out, m_count_valid, m_cmd_err}) begin
        bad++; $display("FAIL rand_cycle%0d: got z=%0b e=%0b c=%0d v=%0b err=%0b want z=%0b e=%0b c=%0d v=%0b err=%0b",
                        i, zero, E, count_out, count_valid, cmd_err,
                        (m_r1 == '0), m_e, m_count_out, m_count_valid, m_cmd_err);
      end
    end
    load_regs = 1'b0; incr_r2 = 1'b0; shift = 1'b0; rdy = 1'b1;
  endtask

  // Reset in the middle of a count (after loading 0xFF, during S_2).
  task automatic test_reset_mid_op();
    @(negedge clk);
    data_in = 8'hFF; load_regs = 1'b1; rdy = 1'b1;
    @(negedge clk);
    load_regs = 1'b0; rdy = 1'b0; incr_r2 = 1'b1;
    @(negedge clk);
    incr_r2 = 1'b0; shift = 1'b1;
    #2 rst_b = 1'b0;
    #1;
    total++;
    if ({zero, E, count_out, count_valid, cmd_err} !== {1'b1, 1'b0, {CW{1'b0}}, 1'b0, 1'b0}) begin
      bad++; $display("FAIL midop_reset: got z=%0b e=%0b c=%0d v=%0b err=%0b want z=1 e=0 c=0 v=0 err=0",
                      zero, E, count_out, count_valid, cmd_err);
    end
    shift = 1'b0; rdy = 1'b1;
    @(negedge clk);
    rst_b = 1'b1;
    m_count_out = '0; m_count_valid = 1'b0; m_cmd_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (count_valid !== 1'b0 || count_out !== '0) begin
        bad++; $display("FAIL midop_release%0d: got v=%0b c=%0d want v=0 c=0", i, count_valid, count_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_operand();
    test_a5();
    test_boundaries();
    test_back_to_back();
    test_cmd_err();
    test_random_ops();
    test_random_cmds();
    test_random_ops();
    test_reset_mid_op();
    test_zero_operand();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
